// File: rtl/complex_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module   : complex_counter_monitor
// Purpose  : Infers binary/Gray mode of an observed 3-bit counter and flags
//            illegal transitions.
// Revision : 1.0
// ============================================================================
module complex_counter_monitor (
    input  logic       clock,
    input  logic       nreset,
    input  logic       sample,
    input  logic [2:0] count_in,
    input  logic       err_clr,
    output logic       mode_out,
    output logic       locked,
    output logic       error,
    output logic       switch,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SYNC      = 2'd1,
        LOCK_BIN  = 2'd2,
        LOCK_GRAY = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_prev;
    logic       w_bin_ok;
    logic       w_gray_ok;
    logic       w_illegal;
    logic       w_err_now;

    // Gray successor: decode to binary, step, re-encode.
    function automatic logic [2:0] gray_succ(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        b    = b + 3'd1;
        return b ^ (b >> 1);
    endfunction

    always_comb begin
        w_bin_ok  = (count_in == (r_prev + 3'd1));
        w_gray_ok = (count_in == gray_succ(r_prev));
        w_illegal = !w_bin_ok && !w_gray_ok;
        w_err_now = sample && (r_state != IDLE) && w_illegal;
    end

    always_ff @(negedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state   <= IDLE;
            r_prev    <= 3'd0;
            mode_out  <= 1'b0;
            locked    <= 1'b0;
            error     <= 1'b0;
            switch    <= 1'b0;
            err_count <= 8'd0;
        end else begin
            error  <= 1'b0;
            switch <= 1'b0;
            if (sample) begin
                r_prev <= count_in;
                case (r_state)
                    IDLE: r_state <= SYNC;
                    SYNC: begin
                        if (w_illegal) begin
                            error <= 1'b1;
                        end else if (!w_gray_ok) begin
                            r_state  <= LOCK_BIN;
                            mode_out <= 1'b0;
                            locked   <= 1'b1;
                        end else if (!w_bin_ok) begin
                            r_state  <= LOCK_GRAY;
                            mode_out <= 1'b1;
                            locked   <= 1'b1;
                        end
                    end
                    LOCK_BIN: begin
                        if (w_illegal) begin
                            r_state <= SYNC;
                            locked  <= 1'b0;
                            error   <= 1'b1;
                        end else if (!w_bin_ok) begin
                            r_state  <= LOCK_GRAY;
                            mode_out <= 1'b1;
                            switch   <= 1'b1;
                        end
                    end
                    LOCK_GRAY: begin
                        if (w_illegal) begin
                            r_state <= SYNC;
                            locked  <= 1'b0;
                            error   <= 1'b1;
                        end else if (!w_gray_ok) begin
                            r_state  <= LOCK_BIN;
                            mode_out <= 1'b0;
                            switch   <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
            // Clear has priority over a coincident error.
            if (err_clr) begin
                err_count <= 8'd0;
            end else if (w_err_now && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complex_counter_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_counter_monitor
// Purpose  : Directed plus randomized bench with a sequence-table reference model.
// Revision : 1.0
// ============================================================================
module tb_complex_counter_monitor;

    logic       clock;
    logic       nreset;
    logic       sample;
    logic [2:0] count_in;
    logic       err_clr;
    logic       mode_out;
    logic       locked;
    logic       error;
    logic       switch;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 sync, 2 locked-binary, 3 locked-gray
    int         m_state;
    logic [2:0] m_prev;
    logic       m_mode;
    logic       m_err;
    logic       m_sw;
    int         m_cnt;

    int bin_seq[8]  = '{0, 1, 2, 3, 4, 5, 6, 7};
    int gray_seq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    complex_counter_monitor dut (
        .clock    (clock),
        .nreset   (nreset),
        .sample   (sample),
        .count_in (count_in),
        .err_clr  (err_clr),
        .mode_out (mode_out),
        .locked   (locked),
        .error    (error),
        .switch   (switch),
        .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int succ(input bit gray, input int p);
        for (int i = 0; i < 8; i++) begin
            if (gray && gray_seq[i] == p) return gray_seq[(i + 1) % 8];
            if (!gray && bin_seq[i] == p) return bin_seq[(i + 1) % 8];
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_prev = 3'd0; m_mode = 1'b0;
        m_err = 1'b0; m_sw = 1'b0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic s, input logic [2:0] v, input logic clr);
        bit b, g;
        m_err = 1'b0;
        m_sw  = 1'b0;
        if (s) begin
            b = (succ(1'b0, int'(m_prev)) == int'(v));
            g = (succ(1'b1, int'(m_prev)) == int'(v));
            if (m_state == 0) begin
                m_state = 1;
            end else if (!b && !g) begin
                m_err = 1'b1;
                m_state = 1;
            end else if (m_state == 1) begin
                if (b && !g) begin m_state = 2; m_mode = 1'b0; end
                if (g && !b) begin m_state = 3; m_mode = 1'b1; end
            end else if (m_state == 2 && !b) begin
                m_state = 3; m_mode = 1'b1; m_sw = 1'b1;
            end else if (m_state == 3 && !g) begin
                m_state = 2; m_mode = 1'b0; m_sw = 1'b1;
            end
            m_prev = v;
        end
        if (clr) m_cnt = 0;
        else if (m_err && m_cnt < 255) m_cnt++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mode"},   {7'd0, mode_out}, {7'd0, m_mode});
        chk({tag, ".locked"}, {7'd0, locked},   {7'd0, (m_state >= 2)});
        chk({tag, ".error"},  {7'd0, error},    {7'd0, m_err});
        chk({tag, ".switch"}, {7'd0, switch},   {7'd0, m_sw});
        chk({tag, ".errcnt"}, err_count,        8'(m_cnt));
    endtask

    task automatic step(input logic s, input logic [2:0] v, input logic clr, input string tag);
        @(posedge clock);
        sample = s; count_in = v; err_clr = clr;
        @(negedge clock);
        model_edge(s, v, clr);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock);
        nreset = 1'b0;
        sample = 1'b0; err_clr = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clock);
        @(posedge clock);
        nreset = 1'b1;
    endtask

    initial begin
        int v;
        int r;
        nreset = 1'b1; sample = 1'b0; count_in = 3'd0; err_clr = 1'b0;
        model_reset();
        #2;
        do_reset("rst0");

        // Binary lock after the first unambiguous pair
        step(1, 3'd0, 0, "bin0");
        step(1, 3'd1, 0, "bin1");
        chk("bin_sync_unlocked", {7'd0, locked}, 8'd0);
        step(1, 3'd2, 0, "bin2");
        chk("bin_locked", {7'd0, locked}, 8'd1);
        chk("bin_mode", {7'd0, mode_out}, 8'd0);
        step(0, 3'd5, 0, "gap");
        // Binary -> Gray switch from value 2
        step(1, 3'd6, 0, "sw26");
        chk("switch_pulse", {7'd0, switch}, 8'd1);
        step(1, 3'd7, 0, "sw_after");
        chk("switch_one_cycle", {7'd0, switch}, 8'd0);

        // Gray run
        do_reset("rst1");
        foreach (gray_seq[i]) step(1, 3'(gray_seq[i]), 0, "gray");
        step(1, 3'd0, 0, "gray_wrap");
        chk("gray_mode", {7'd0, mode_out}, 8'd1);

        // Error from LOCK_BIN then relock
        do_reset("rst2");
        step(1, 3'd1, 0, "e1");
        step(1, 3'd2, 0, "e2");
        step(1, 3'd3, 0, "e3");
        step(1, 3'd3, 0, "e_rep");
        chk("err_count_one", err_count, 8'd1);
        step(1, 3'd4, 0, "relock");
        chk("relock_locked", {7'd0, locked}, 8'd1);

        // Saturation and clear priority
        for (int i = 0; i < 260; i++) step(1, 3'd4, 0, "sat");
        chk("sat_255", err_count, 8'd255);
        step(1, 3'd4, 1, "clr_win");
        chk("clr_zero", err_count, 8'd0);

        // Reset mid-Gray: first sample afterwards is never checked
        do_reset("rst3");
        for (int i = 0; i < 7; i++) step(1, 3'(gray_seq[i]), 0, "gray_mid");
        do_reset("rst4");
        step(1, 3'd5, 0, "post_rst");
        chk("post_rst_noerr", {7'd0, error}, 8'd0);
        step(1, 3'd4, 0, "post_rst_lock");

        // Randomized traffic biased toward legal transitions
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset("rnd_rst");
            end else begin
                r = $urandom_range(0, 9);
                if (r < 5)      v = succ(1'b0, int'(m_prev));
                else if (r < 8) v = succ(1'b1, int'(m_prev));
                else            v = $urandom_range(0, 7);
                step(1'($urandom_range(0, 3) != 0), 3'(v),
                     1'($urandom_range(0, 29) == 0), "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/complex_counter_monitor.md
COMPLEX_COUNTER_MONITOR -- requirements
Module: complex_counter_monitor

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
REQ-002 clock  input  1  the single clock; all state SHALL update on the negative edge.
REQ-003 nreset  input  1  asynchronous active-low reset.
REQ-004 sample  input  1  qualifies count_in; count_in SHALL be ignored on edges where sample=0.
REQ-005 count_in  input  3  observed count value from a mode-controlled 3-bit counter.
REQ-006 err_clr  input  1  synchronous clear of err_count.
REQ-007 mode_out  output  1  inferred counter mode: 0=binary up, 1=Gray.
REQ-008 locked  output  1  high while the inferred mode is established.
REQ-009 error  output  1  one-cycle pulse on an illegal transition.
REQ-010 switch  output  1  one-cycle pulse when the locked mode changes.
REQ-011 err_count  output  8  saturating count of illegal transitions.

Function
REQ-012 Binary sequence SHALL be 0-1-2-3-4-5-6-7-0.
REQ-013 Gray sequence SHALL be 000-001-011-010-110-111-101-100-000.
REQ-014 A transition SHALL be the pair (previous sampled value, current sampled value).
REQ-015 Pairs 0->1 and 6->7 are legal in both sequences and SHALL be classed ambiguous.
REQ-016 Any pair legal in neither sequence, including a repeated value, SHALL be classed illegal.
REQ-017 FSM states SHALL be IDLE, SYNC, LOCK_BIN and LOCK_GRAY.
REQ-018 IDLE, sample: store count_in as the previous value and go to SYNC, with no error.
REQ-019 SYNC, binary-only pair: go to LOCK_BIN with mode_out=0.
REQ-020 SYNC, Gray-only pair: go to LOCK_GRAY with mode_out=1.
REQ-021 SYNC, ambiguous pair: stay in SYNC.
REQ-022 SYNC, illegal pair: stay in SYNC and pulse error.
REQ-023 LOCK_x, pair legal for the current mode (including ambiguous): stay in LOCK_x.
REQ-024 LOCK_x, pair legal only for the other mode: go to the other LOCK state, toggle mode_out and pulse switch.
REQ-025 LOCK_x, illegal pair: go to SYNC, drop locked, pulse error and hold mode_out.
REQ-026 Every sample in every state SHALL overwrite the previous value, including samples that produce an error.
REQ-027 locked SHALL be 1 exactly in LOCK_BIN and LOCK_GRAY.
REQ-028 All outputs SHALL be registered and reflect a sample on the same negative edge that captures it (one-edge latency).
REQ-029 error and switch SHALL be 0 on any edge without sample.
REQ-030 err_count SHALL increment by 1 on each error pulse and saturate at 255.
REQ-031 If err_clr and an error pulse occur on the same edge, err_clr SHALL win and err_count SHALL become 0.
REQ-032 Gaps between samples (sample=0) SHALL NOT affect state or the previous value.

Reset
REQ-033 nreset=0 SHALL immediately force: state=IDLE, previous value=000, mode_out=0, locked=0, error=0, switch=0, err_count=0.
REQ-034 Reset asserted mid-sequence SHALL discard the previous value, so the first sample after release is never checked.
REQ-035 Release of nreset SHALL take effect on the first negative edge after deassertion.

Verification
REQ-036 Reset, then sample 0,1,2,3 -> after 0,1: SYNC with locked=0; after 2: LOCK_BIN, locked=1, mode_out=0.
REQ-037 Reset, then sample 0,1,3,2,6,7,5,4,0 -> LOCK_GRAY after 3, mode_out=1, no error, no switch.
REQ-038 In LOCK_BIN at value 2, sample 6 -> LOCK_GRAY, switch pulses for 1 cycle, mode_out=1, locked stays 1.
REQ-039 In LOCK_BIN at value 3, sample 3 -> error pulse, err_count=1, locked=0; then sample 4 -> LOCK_BIN.
REQ-040 Force 256 illegal repeats -> err_count holds at 255; err_clr together with an error -> err_count=0.
REQ-041 Assert nreset mid-Gray run, then release and sample 5 -> IDLE->SYNC, no error, all outputs at reset values.
